// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared LFSR constants, state enum
// and feedback function for generator and checker.
package lfsr_pkg;

  localparam int          WIDTH_DEF = 16;
  localparam logic [15:0] TAPS_DEF  = 16'hB400;

  typedef enum logic {
    SEED,
    LOCKED
  } state_e;

  function automatic logic lfsr_fb(
    input logic [WIDTH_DEF-1:0] state,
    input logic [WIDTH_DEF-1:0] taps
  );
    return ^(state & taps);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones,
// with a synchronous clear that beats increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  // clear first, then saturating increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/lfsr_checker.sv
// lfsr_checker: self-seeding PRBS receiver with
// bit-error counting and windowed loss-of-lock.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int               WIDTH       = WIDTH_DEF,
  parameter logic [WIDTH-1:0] TAPS        = TAPS_DEF,
  parameter int               WINDOW      = 64,
  parameter int               LOSS_THRESH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sh_en,
  input  logic             din,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [15:0]      err_count,
  output logic [15:0]      bit_count,
  output logic [7:0]       relock_count,
  output logic [WIDTH-1:0] state_q
);

  localparam int SCW = $clog2(WIDTH);
  localparam int WCW = $clog2(WINDOW);
  localparam int ECW = $clog2(LOSS_THRESH + 1);

  localparam logic [SCW-1:0] SEED_LAST = SCW'(WIDTH - 1);
  localparam logic [WCW-1:0] WIN_LAST  = WCW'(WINDOW - 1);
  localparam logic [ECW-1:0] ERR_LIM   = ECW'(LOSS_THRESH);

  state_e           r_fsm;
  state_e           w_fsm_n;
  logic [WIDTH-1:0] r_s;
  logic [WIDTH-1:0] w_s_n;
  logic [WIDTH-1:0] w_seed_s;
  logic [SCW-1:0]   r_seed_cnt;
  logic [SCW-1:0]   w_seed_n;
  logic [WCW-1:0]   r_win_cnt;
  logic [WCW-1:0]   w_wcnt_n;
  logic [ECW-1:0]   r_win_err;
  logic [ECW-1:0]   w_werr_n;
  logic [ECW-1:0]   w_werr_inc;
  logic             r_err_pulse;
  logic             w_pred;
  logic             w_mis;
  logic             w_bit_inc;
  logic             w_relock_inc;

  // next-state: seed from din, then track by prediction
  always_comb begin
    w_fsm_n      = r_fsm;
    w_s_n        = r_s;
    w_seed_n     = r_seed_cnt;
    w_wcnt_n     = r_win_cnt;
    w_werr_n     = r_win_err;
    w_mis        = 1'b0;
    w_bit_inc    = 1'b0;
    w_relock_inc = 1'b0;
    w_pred       = lfsr_fb(r_s, TAPS);
    w_seed_s     = {r_s[WIDTH-2:0], din};
    w_werr_inc   = r_win_err + ECW'(din != w_pred);
    if (sh_en) begin
      case (r_fsm)
        SEED: begin
          w_s_n = w_seed_s;
          if (r_seed_cnt == SEED_LAST) begin
            w_seed_n = '0;
            if (|w_seed_s) begin
              w_fsm_n  = LOCKED;
              w_wcnt_n = '0;
              w_werr_n = '0;
            end
          end else begin
            w_seed_n = r_seed_cnt + 1'b1;
          end
        end
        LOCKED: begin
          w_s_n     = {r_s[WIDTH-2:0], w_pred};
          w_bit_inc = 1'b1;
          w_mis     = (din != w_pred);
          if (w_werr_inc == ERR_LIM) begin
            w_fsm_n      = SEED;
            w_relock_inc = 1'b1;
            w_seed_n     = '0;
            w_wcnt_n     = '0;
            w_werr_n     = '0;
          end else if (r_win_cnt == WIN_LAST) begin
            w_wcnt_n = '0;
            w_werr_n = '0;
          end else begin
            w_wcnt_n = r_win_cnt + 1'b1;
            w_werr_n = w_werr_inc;
          end
        end
        default: ;
      endcase
    end
  end

  // state and window registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fsm       <= SEED;
      r_s         <= '0;
      r_seed_cnt  <= '0;
      r_win_cnt   <= '0;
      r_win_err   <= '0;
      r_err_pulse <= 1'b0;
    end else begin
      r_fsm       <= w_fsm_n;
      r_s         <= w_s_n;
      r_seed_cnt  <= w_seed_n;
      r_win_cnt   <= w_wcnt_n;
      r_win_err   <= w_werr_n;
      r_err_pulse <= w_mis;
    end
  end

  sat_counter #(.W(16)) u_err_cnt (
    .clk   (clk),
    .rst_n (reset_n),
    .inc   (w_mis),
    .clr   (clr_cnt),
    .count (err_count)
  );

  sat_counter #(.W(16)) u_bit_cnt (
    .clk   (clk),
    .rst_n (reset_n),
    .inc   (w_bit_inc),
    .clr   (clr_cnt),
    .count (bit_count)
  );

  sat_counter #(.W(8)) u_relock_cnt (
    .clk   (clk),
    .rst_n (reset_n),
    .inc   (w_relock_inc),
    .clr   (clr_cnt),
    .count (relock_count)
  );

  assign locked    = (r_fsm == LOCKED);
  assign err_pulse = r_err_pulse;
  assign state_q   = r_s;

endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: directed scoreboard bench for
// lfsr_checker driven by a reference PRBS source.
module tb_lfsr_checker;

  logic        clk;
  logic        reset_n;
  logic        sh_en;
  logic        din;
  logic        clr_cnt;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
  logic [15:0] bit_count;
  logic [7:0]  relock_count;
  logic [15:0] state_q;

  typedef struct {
    int          tag;
    int          n;
    bit          lk;
    bit          ep;
    int          ec;
    int          bc;
    int          rc;
    bit          cs;
    logic [15:0] st;
  } exp_t;

  exp_t        sbq[$];
  exp_t        m_e;
  int          n_chk;
  int          n_err;
  logic [15:0] g;

  lfsr_checker dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sh_en        (sh_en),
    .din          (din),
    .clr_cnt      (clr_cnt),
    .locked       (locked),
    .err_pulse    (err_pulse),
    .err_count    (err_count),
    .bit_count    (bit_count),
    .relock_count (relock_count),
    .state_q      (state_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input int    tag,
    input int    n,
    input string nm,
    input int    act,
    input int    req
  );
    n_chk++;
    if (act != req) begin
      n_err++;
      $display("FAIL t%0d bit%0d %s: got %0d expected %0d",
               tag, n, nm, act, req);
    end
  endtask

  // reference generator: Fibonacci, taps 15,13,12,10
  task automatic gen(output logic b);
    b = ^(g & 16'hB400);
    g = {g[14:0], b};
  endtask

  function automatic exp_t mk(
    input int tag, input int n, input bit lk,
    input bit ep, input int ec, input int bc,
    input int rc, input bit cs
  );
    exp_t e;
    e.tag = tag; e.n = n; e.lk = lk; e.ep = ep;
    e.ec = ec; e.bc = bc; e.rc = rc; e.cs = cs;
    e.st = g;
    return e;
  endfunction

  task automatic send(
    input bit v, input bit d, input bit c, input exp_t e
  );
    @(negedge clk);
    sh_en   = v;
    din     = d;
    clr_cnt = c;
    sbq.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    sh_en   = 1'b0;
    din     = 1'b0;
    clr_cnt = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // monitor: pop one expectation per driven cycle
  always @(posedge clk) begin
    #1;
    if (sbq.size() > 0) begin
      m_e = sbq.pop_front();
      chk(m_e.tag, m_e.n, "locked", int'(locked), int'(m_e.lk));
      chk(m_e.tag, m_e.n, "err_pulse", int'(err_pulse), int'(m_e.ep));
      chk(m_e.tag, m_e.n, "err_count", int'(err_count), m_e.ec);
      chk(m_e.tag, m_e.n, "bit_count", int'(bit_count), m_e.bc);
      chk(m_e.tag, m_e.n, "relock_count", int'(relock_count), m_e.rc);
      if (m_e.cs)
        chk(m_e.tag, m_e.n, "state_q", int'(state_q), int'(m_e.st));
    end
  end

  initial begin
    logic b;
    int   n;
    int   bc;
    int   ec;
    bit   v;
    n_chk   = 0;
    n_err   = 0;
    reset_n = 1'b0;
    sh_en   = 1'b0;
    din     = 1'b0;
    clr_cnt = 1'b0;
    g       = 16'hACE1;

    // 1: clean lock, 1000 bits
    do_reset();
    send(0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0, 1'b0));
    g = 16'hACE1;
    for (int i = 1; i <= 1000; i++) begin
      gen(b);
      send(1, b, 0, mk(1, i, i >= 16, 0, 0,
                       (i > 16) ? i - 16 : 0, 0, i >= 16));
    end

    // 2: single inverted bit 200
    do_reset();
    g = 16'hACE1;
    for (int i = 1; i <= 1000; i++) begin
      gen(b);
      send(1, b ^ (i == 200), 0,
           mk(2, i, i >= 16, i == 200, (i >= 200) ? 1 : 0,
              (i > 16) ? i - 16 : 0, 0, i >= 16));
    end

    // 3: burst of 8 errors at bits 100..107
    do_reset();
    g = 16'hACE1;
    for (int i = 1; i <= 300; i++) begin
      gen(b);
      if (i <= 107)      bc = (i > 16) ? i - 16 : 0;
      else if (i <= 123) bc = 91;
      else               bc = 91 + i - 123;
      if (i < 100)       ec = 0;
      else if (i <= 107) ec = i - 99;
      else               ec = 8;
      v = (i >= 16) && ((i < 107) || (i >= 123));
      send(1, b ^ ((i >= 100) && (i <= 107)), 0,
           mk(3, i, v, (i >= 100) && (i <= 107), ec, bc,
              (i >= 107) ? 1 : 0, v));
    end

    // 4: all-zero input never locks
    do_reset();
    g = 16'h0000;
    for (int i = 1; i <= 200; i++)
      send(1, 0, 0, mk(4, i, 0, 0, 0, 0, 0, 1'b1));

    // 5: random gaps in sh_en
    do_reset();
    g = 16'hACE1;
    n = 0;
    for (int i = 1; i <= 400; i++) begin
      v = 1'($urandom_range(0, 1));
      if (v) begin
        gen(b);
        n++;
      end else begin
        b = 1'($urandom_range(0, 1));
      end
      send(v, b, 0, mk(5, n, n >= 16, 0, 0,
                       (n > 16) ? n - 16 : 0, 0, n >= 16));
    end

    // 6: clear together with a counted error
    do_reset();
    g = 16'hACE1;
    for (int i = 1; i <= 80; i++) begin
      gen(b);
      if (i < 50)       bc = (i > 16) ? i - 16 : 0;
      else              bc = i - 50;
      send(1, b ^ (i == 50), i == 50,
           mk(6, i, i >= 16, i == 50, 0, bc, 0, i >= 16));
    end

    // 7: asynchronous reset while locked
    do_reset();
    g = 16'hACE1;
    for (int i = 1; i <= 100; i++) begin
      gen(b);
      send(1, b, 0, mk(7, i, i >= 16, 0, 0,
                       (i > 16) ? i - 16 : 0, 0, i >= 16));
    end
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    sh_en   = 1'b0;
    #1;
    chk(7, 0, "rst_locked", int'(locked), 0);
    chk(7, 0, "rst_err_pulse", int'(err_pulse), 0);
    chk(7, 0, "rst_err_count", int'(err_count), 0);
    chk(7, 0, "rst_bit_count", int'(bit_count), 0);
    chk(7, 0, "rst_relock", int'(relock_count), 0);
    chk(7, 0, "rst_state_q", int'(state_q), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      gen(b);
      send(1, b, 0, mk(7, 100 + i, i >= 16, 0, 0,
                       (i > 16) ? i - 16 : 0, 0, i >= 16));
    end

    @(negedge clk);
    sh_en = 1'b0;
    for (int k = 0; k < 10 && sbq.size() > 0; k++)
      @(posedge clk);
    #2;
    n_chk++;
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0",
               sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
